stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_stall_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// stall_ctrl: ID-stage hazard detection for a 5-stage MIPS-style pipeline.
// Covers load-use, early branch operands and the mult/div busy window.
module stall_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic [31:0] instrE,
  input  logic [31:0] instrM,
  input  logic        clr_perf,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [15:0] stall_cycles
);

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  function automatic logic f_cal_r(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == 6'h00) && (fn inside {[6'h20:6'h2B]});
  endfunction

  function automatic logic f_cal_i(input logic [5:0] op);
    return op inside {[6'h08:6'h0F]};
  endfunction

  function automatic logic f_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic logic f_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic logic f_branch(input logic [5:0] op);
    return op inside {6'h04, 6'h05};
  endfunction

  function automatic logic f_jr(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == 6'h00) && (fn == 6'h08);
  endfunction

  function automatic logic f_md_op(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == 6'h00) && (fn inside {[6'h18:6'h1B]});
  endfunction

  function automatic logic f_md_mv(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == 6'h00) && (fn inside {[6'h10:6'h13]});
  endfunction

  // ID fields and classes
  logic [5:0] op_d;
  logic [5:0] fn_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       cal_r_d;
  logic       cal_i_d;
  logic       load_d;
  logic       store_d;
  logic       branch_d;
  logic       jr_d;
  logic       md_op_d;
  logic       md_mv_d;
  logic       mthi_d;
  logic       mtlo_d;
  logic       use_rs_d;
  logic       use_rt_d;

  // EX fields and classes
  logic [5:0] op_e;
  logic [5:0] fn_e;
  logic [4:0] rt_e;
  logic [4:0] rd_e;
  logic       cal_r_e;
  logic       cal_i_e;
  logic       load_e;
  logic       md_op_e;
  logic       mult_e;
  logic       div_e;
  logic [4:0] dst_e;

  // MEM fields and classes
  logic [5:0] op_m;
  logic [4:0] rt_m;
  logic       load_m;

  // Hazard terms
  logic       s1;
  logic       s2;
  logic       s3;
  logic       s4;
  logic       early_d;
  logic [3:0] md_nxt;

  // Instruction bits no hazard rule looks at
  logic unused_bits;
  assign unused_bits = ^{instrD[15:6], instrE[25:21],
                         instrE[10:6], instrM[25:21],
                         instrM[15:0]};

  // Decode the instruction sitting in ID
  always_comb begin
    op_d     = instrD[31:26];
    fn_d     = instrD[5:0];
    rs_d     = instrD[25:21];
    rt_d     = instrD[20:16];
    cal_r_d  = f_cal_r(op_d, fn_d);
    cal_i_d  = f_cal_i(op_d);
    load_d   = f_load(op_d);
    store_d  = f_store(op_d);
    branch_d = f_branch(op_d);
    jr_d     = f_jr(op_d, fn_d);
    md_op_d  = f_md_op(op_d, fn_d);
    md_mv_d  = f_md_mv(op_d, fn_d);
    mthi_d   = md_mv_d && (fn_d == 6'h11);
    mtlo_d   = md_mv_d && (fn_d == 6'h13);
    use_rs_d = cal_r_d | cal_i_d | load_d
             | store_d | branch_d | jr_d
             | md_op_d | mthi_d | mtlo_d;
    use_rt_d = cal_r_d | store_d | branch_d
             | md_op_d;
    early_d  = branch_d | jr_d;
  end

  // Decode EX and pick its destination register
  always_comb begin
    op_e    = instrE[31:26];
    fn_e    = instrE[5:0];
    rt_e    = instrE[20:16];
    rd_e    = instrE[15:11];
    cal_r_e = f_cal_r(op_e, fn_e);
    cal_i_e = f_cal_i(op_e);
    load_e  = f_load(op_e);
    md_op_e = f_md_op(op_e, fn_e);
    mult_e  = md_op_e && !fn_e[1];
    div_e   = md_op_e && fn_e[1];
    dst_e   = 5'd0;
    unique case (1'b1)
      cal_r_e:          dst_e = rd_e;
      cal_i_e | load_e: dst_e = rt_e;
      default:          dst_e = 5'd0;
    endcase
  end

  // Decode MEM; only a load there can still hurt a branch
  always_comb begin
    op_m   = instrM[31:26];
    rt_m   = instrM[20:16];
    load_m = f_load(op_m);
  end

  // Combine the four stall sources
  always_comb begin
    s1 = load_e && (rt_e != 5'd0)
      && ((use_rs_d && (rs_d == rt_e))
       || (use_rt_d && (rt_d == rt_e)));
    s2 = (cal_r_e | cal_i_e) && (dst_e != 5'd0)
      && ((early_d && (rs_d == dst_e))
       || (branch_d && (rt_d == dst_e)));
    s3 = load_m && (rt_m != 5'd0)
      && ((early_d && (rs_d == rt_m))
       || (branch_d && (rt_d == rt_m)));
    s4 = (md_op_d | md_mv_d)
      && (md_busy | md_op_e);
  end

  assign stall   = s1 | s2 | s3 | s4;
  assign flush_E = stall;
  assign md_busy = md_cnt != 4'd0;

  // A new mult/div in EX always reloads, even mid-count
  always_comb begin
    md_nxt = 4'd0;
    if (mult_e)
      md_nxt = MULT_LAT;
    else if (div_e)
      md_nxt = DIV_LAT;
    else if (md_busy)
      md_nxt = md_cnt - 4'd1;
  end

  // Mult/div countdown register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      md_cnt <= 4'd0;
    else
      md_cnt <= md_nxt;
  end

  // Saturating stall-cycle counter, clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cycles <= 16'd0;
    else if (clr_perf)
      stall_cycles <= 16'd0;
    else if (stall && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed vectors plus a per-cycle reference model
// computed from register read/write sets and a busy-until cycle.
module tb_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instrD;
  logic [31:0] instrE;
  logic [31:0] instrM;
  logic        clr_perf;
  logic        stall;
  logic        flush_E;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad = 0;

  stall_ctrl dut (
    .clk(clk),
    .reset(reset),
    .instrD(instrD),
    .instrE(instrE),
    .instrM(instrM),
    .clr_perf(clr_perf),
    .stall(stall),
    .flush_E(flush_E),
    .md_busy(md_busy),
    .md_cnt(md_cnt),
    .stall_cycles(stall_cycles)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------- encoders ----------
  function automatic logic [31:0] rtype(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  // ---------- reference model ----------
  function automatic int opc(input logic [31:0] i);
    return int'(i[31:26]);
  endfunction
  function automatic int fnc(input logic [31:0] i);
    return int'(i[5:0]);
  endfunction
  function automatic bit r_alu(input logic [31:0] i);
    return opc(i) == 0 && fnc(i) >= 32 && fnc(i) <= 43;
  endfunction
  function automatic bit i_alu(input logic [31:0] i);
    return opc(i) >= 8 && opc(i) <= 15;
  endfunction
  function automatic bit is_ld(input logic [31:0] i);
    int o;
    o = opc(i);
    return o == 32 || o == 33 || o == 35 || o == 36 || o == 37;
  endfunction
  function automatic bit is_st(input logic [31:0] i);
    int o;
    o = opc(i);
    return o == 40 || o == 41 || o == 43;
  endfunction
  function automatic bit is_br(input logic [31:0] i);
    return opc(i) == 4 || opc(i) == 5;
  endfunction
  function automatic bit is_jr(input logic [31:0] i);
    return opc(i) == 0 && fnc(i) == 8;
  endfunction
  function automatic bit is_md(input logic [31:0] i);
    return opc(i) == 0 && fnc(i) >= 24 && fnc(i) <= 27;
  endfunction
  function automatic bit is_hilo(input logic [31:0] i);
    return is_md(i) || (opc(i) == 0 && fnc(i) >= 16 && fnc(i) <= 19);
  endfunction
  function automatic int dest(input logic [31:0] i);
    if (r_alu(i)) return int'(i[15:11]);
    if (i_alu(i) || is_ld(i)) return int'(i[20:16]);
    return 0;
  endfunction
  function automatic bit reads(input logic [31:0] i, input int r);
    bit a;
    bit b;
    a = r_alu(i) || i_alu(i) || is_ld(i) || is_st(i) || is_br(i)
      || is_jr(i) || is_md(i)
      || (opc(i) == 0 && (fnc(i) == 17 || fnc(i) == 19));
    b = r_alu(i) || is_st(i) || is_br(i) || is_md(i);
    return r != 0 && ((a && int'(i[25:21]) == r)
                   || (b && int'(i[20:16]) == r));
  endfunction
  function automatic bit reads_early(input logic [31:0] i, input int r);
    return r != 0
      && (((is_br(i) || is_jr(i)) && int'(i[25:21]) == r)
       || (is_br(i) && int'(i[20:16]) == r));
  endfunction
  function automatic bit want_stall(input bit busy);
    return (is_ld(instrE) && reads(instrD, int'(instrE[20:16])))
        || ((r_alu(instrE) || i_alu(instrE))
            && reads_early(instrD, dest(instrE)))
        || (is_ld(instrM) && reads_early(instrD, int'(instrM[20:16])))
        || (is_hilo(instrD) && (busy || is_md(instrE)));
  endfunction

  int cyc = 0;
  int busy_until = 0;
  int perf = 0;

  function automatic int rem();
    return (busy_until > cyc) ? busy_until - cyc : 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_until = cyc;
      perf = 0;
    end else begin
      bit s;
      s = want_stall(rem() > 0);
      cyc = cyc + 1;
      if (is_md(instrE))
        busy_until = cyc + ((fnc(instrE) <= 25) ? 5 : 10);
      if (clr_perf) perf = 0;
      else if (s && perf < 65535) perf = perf + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit es;
    es = want_stall(rem() > 0);
    chk("m_stall", int'(stall), int'(es));
    chk("m_flush", int'(flush_E), int'(es));
    chk("m_busy", int'(md_busy), int'(rem() > 0));
    chk("m_cnt", int'(md_cnt), rem());
    chk("m_perf", int'(stall_cycles), perf);
  end

  // ---------- directed stimulus ----------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
    #1;
  endtask
  task automatic put(input logic [31:0] d, input logic [31:0] e,
                     input logic [31:0] m);
    instrD = d;
    instrE = e;
    instrM = m;
  endtask

  logic [31:0] lw8, lw0_1, addu9, addu8, beq8, beq00;
  logic [31:0] mult12, div12, mflo3;

  initial begin
    lw8    = itype(6'h23, 5'd0, 5'd8);
    lw0_1  = itype(6'h23, 5'd1, 5'd0);
    addu9  = rtype(5'd8, 5'd1, 5'd9, 6'h21);
    addu8  = rtype(5'd2, 5'd3, 5'd8, 6'h21);
    beq8   = itype(6'h04, 5'd8, 5'd0);
    beq00  = itype(6'h04, 5'd0, 5'd0);
    mult12 = rtype(5'd1, 5'd2, 5'd0, 6'h18);
    div12  = rtype(5'd1, 5'd2, 5'd0, 6'h1A);
    mflo3  = rtype(5'd0, 5'd0, 5'd3, 6'h12);

    reset = 0;
    clr_perf = 0;
    put(0, 0, 0);
    mid();
    chk("rst_cnt", int'(md_cnt), 0);
    chk("rst_perf", int'(stall_cycles), 0);
    chk("rst_stall", int'(stall), 0);
    tick();
    reset = 1;

    // load-use
    put(addu9, lw8, 0);
    mid();
    chk("lu_stall", int'(stall), 1);
    chk("lu_flush", int'(flush_E), 1);
    tick();
    chk("lu_perf", int'(stall_cycles), 1);
    put(0, 0, 0);
    tick();

    // ALU result feeding a branch vs an ALU op
    put(beq8, addu8, 0);
    mid();
    chk("alu_br", int'(stall), 1);
    tick();
    put(addu9, addu8, 0);
    mid();
    chk("alu_alu", int'(stall), 0);
    tick();

    // zero register never stalls
    put(beq00, lw0_1, 0);
    mid();
    chk("zero_reg", int'(stall), 0);
    tick();

    // load in MEM feeding branch vs ALU
    put(beq8, 0, lw8);
    mid();
    chk("ldm_br", int'(stall), 1);
    tick();
    put(addu9, 0, lw8);
    mid();
    chk("ldm_alu", int'(stall), 0);
    tick();

    // mult countdown with mflo waiting in ID
    put(0, mult12, 0);
    mid();
    chk("mul_idle", int'(md_busy), 0);
    tick();
    put(mflo3, 0, 0);
    for (int k = 5; k >= 0; k--) begin
      mid();
      chk("mul_cnt", int'(md_cnt), k);
      chk("mul_stall", int'(stall), int'(k != 0));
      tick();
    end

    // div in EX with mflo in ID, then reset mid-count
    put(mflo3, div12, 0);
    mid();
    chk("div_e_stall", int'(stall), 1);
    tick();
    put(0, 0, 0);
    repeat (4) tick();
    mid();
    chk("div_cnt6", int'(md_cnt), 6);
    reset = 0;
    #1;
    chk("rst_async", int'(md_cnt), 0);
    chk("rst_busy", int'(md_busy), 0);
    put(addu9, lw8, 0);
    mid();
    chk("rst_s1", int'(stall), 1);
    tick();
    chk("rst_noinc", int'(stall_cycles), 0);
    reset = 1;
    put(mflo3, 0, 0);
    mid();
    chk("post_rst", int'(stall), 0);
    tick();

    // saturation and clear
    put(addu9, lw8, 0);
    repeat (65536) tick();
    mid();
    chk("sat", int'(stall_cycles), 16'hFFFF);
    clr_perf = 1;
    tick();
    clr_perf = 0;
    mid();
    chk("clr", int'(stall_cycles), 0);
    tick();
    chk("after_clr", int'(stall_cycles), 1);
    put(0, 0, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
